// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU for the MIPS datapath.
// Logic/arith/shift ops retire one clock after an accepted start; MUL (shift-add)
// and DIV (restoring) iterate for WIDTH clocks while busy is high.
// Optional feature macro: ALU_SEQ_REM_EN adds the alu_rem port and opcode 1111 (REM).
`timescale 1ns/1ps

module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [SHW-1:0]   shamnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
`ifdef ALU_SEQ_REM_EN
  output logic [WIDTH-1:0] alu_rem,
`endif
  output logic [7:0]       alu_status
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_SLL = 4'b1011;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SRA = 4'b1110;
`ifdef ALU_SEQ_REM_EN
  localparam logic [3:0] OP_REM = 4'b1111;
`endif

  // Counter must reach WIDTH for REM's extra retire cycle.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand (MUL) or divisor (DIV/REM)
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier shifting out / quotient shifting in

  // Single-cycle datapath, driven straight from the inputs sampled at the accepting edge.
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c, carry_c, div0_c;
`ifdef ALU_SEQ_REM_EN
  logic [WIDTH-1:0] rem_c;
`endif

  assign add_w = {1'b0, operand_1} + {1'b0, operand_2};
  assign sub_w = {1'b0, operand_1} - {1'b0, operand_2};

  // Result and flag sources for ops that retire in one clock.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    res_c   = '0;
    ovf_c   = 1'b0;
    carry_c = 1'b0;
    div0_c  = 1'b0;
`ifdef ALU_SEQ_REM_EN
    rem_c   = '0;
`endif
    case (alu_ctrl)
      OP_ADD: begin
        res_c   = add_w[WIDTH-1:0];
        carry_c = add_w[WIDTH];
        ovf_c   = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                  (add_w[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = sub_w[WIDTH-1:0];
        carry_c = sub_w[WIDTH];
        ovf_c   = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_AND: res_c = operand_1 & operand_2;
      OP_OR:  res_c = operand_1 | operand_2;
      OP_XOR: res_c = operand_1 ^ operand_2;
      OP_NOR: res_c = ~(operand_1 | operand_2);
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, $signed(operand_1) < $signed(operand_2)};
      OP_SLL: res_c = operand_1 << shamnt;
      OP_SRL: res_c = operand_1 >> shamnt;
      OP_SRA: res_c = $unsigned($signed(operand_1) >>> shamnt);
      // MUL/DIV only retire here when B is zero; otherwise they iterate.
      OP_MUL: res_c = '0;
      OP_DIV: begin
        res_c  = '1;
        div0_c = 1'b1;
`ifdef ALU_SEQ_REM_EN
        rem_c  = operand_1;
`endif
      end
`ifdef ALU_SEQ_REM_EN
      OP_REM: begin
        res_c  = operand_1;
        div0_c = 1'b1;
        rem_c  = operand_1;
      end
`endif
      default: res_c = '0;
    endcase
  end

  // Ops that enter the iterative datapath.
  logic is_iter_op, iter_start, is_rem_q, last;
`ifdef ALU_SEQ_REM_EN
  assign is_iter_op = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM);
  assign is_rem_q   = (op_q == OP_REM);
`else
  assign is_iter_op = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_DIV);
  assign is_rem_q   = 1'b0;
`endif
  assign iter_start = is_iter_op && (operand_2 != '0);
  assign last       = is_rem_q ? (cnt == CW'(WIDTH)) : (cnt == CW'(WIDTH - 1));

  // One shift-add or restoring-divide step; the final step feeds the result directly.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, it_res;
  logic             it_ovf;
`ifdef ALU_SEQ_REM_EN
  logic [WIDTH-1:0] it_rem;
`endif

  // Next accumulator values and the retire values of the iterative op.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    nxt_hi    = acc_hi;
    nxt_lo    = acc_lo;
    it_res    = '0;
    it_ovf    = 1'b0;
`ifdef ALU_SEQ_REM_EN
    it_rem    = '0;
`endif
    if (op_q == OP_MUL) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      it_res = nxt_lo;
      it_ovf = (nxt_hi != '0);
    end else begin
      if (!div_diff[WIDTH]) begin
        nxt_hi = div_diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
      // REM retires one clock after the last step, from the stored remainder.
      it_res = is_rem_q ? acc_hi : nxt_lo;
`ifdef ALU_SEQ_REM_EN
      it_rem = is_rem_q ? acc_hi : nxt_hi;
`endif
    end
  end

  function automatic logic [7:0] mk_status(input logic [WIDTH-1:0] r,
                                           input logic ovf, input logic carry,
                                           input logic div0);
    return {(r == '0), ovf, carry, r[WIDTH-1], r[0], div0, 2'b00};
  endfunction

  // Control FSM, operand latching and registered result/status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      opnd_q     <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_result <= '0;
      alu_status <= '0;
`ifdef ALU_SEQ_REM_EN
      alu_rem    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (iter_start) begin
              state  <= ITER;
              busy   <= 1'b1;
              cnt    <= '0;
              op_q   <= alu_ctrl;
              acc_hi <= '0;
              if (alu_ctrl == OP_MUL) begin
                acc_lo <= operand_2;
                opnd_q <= operand_1;
              end else begin
                acc_lo <= operand_1;
                opnd_q <= operand_2;
              end
            end else begin
              done       <= 1'b1;
              alu_result <= res_c;
              alu_status <= mk_status(res_c, ovf_c, carry_c, div0_c);
`ifdef ALU_SEQ_REM_EN
              alu_rem    <= rem_c;
`endif
            end
          end
        end
        ITER: begin
          if (last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            alu_result <= it_res;
            alu_status <= mk_status(it_res, it_ovf, 1'b0, 1'b0);
`ifdef ALU_SEQ_REM_EN
            alu_rem    <= it_rem;
`endif
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=32, default build.
`timescale 1ns/1ps

module tb_alu_seq;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_SLL = 4'b1011;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SRA = 4'b1110;
  localparam logic [3:0] OP_UNK = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] operand_1, operand_2;
  logic [4:0]  shamnt;
  logic        busy, done;
  logic [31:0] alu_result;
  logic [7:0]  alu_status;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;
  int pulses;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .shamnt    (shamnt),
    .busy      (busy),
    .done      (done),
    .alu_result(alu_result),
    .alu_status(alu_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at the falling edge; return #1 after the accepting rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    start     = 1'b1;
    alu_ctrl  = op;
    operand_1 = a;
    operand_2 = b;
    shamnt    = sh;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count rising edges until done is seen, bounded by budget.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Single-cycle op: done must be up right after the accepting edge.
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input logic [7:0] exp_st);
    issue(op, a, b, sh);
    check({tag, " done"},   {31'd0, done}, 32'd1);
    check({tag, " result"}, alu_result,    exp_res);
    check({tag, " status"}, {24'd0, alu_status}, {24'd0, exp_st});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; alu_ctrl = '0; operand_1 = '0; operand_2 = '0; shamnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset result", alu_result, 32'd0);
    check("reset status", {24'd0, alu_status}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle ops.
    single("add ovf",  OP_ADD, 32'h7FFF_FFFF, 32'd1,  5'd0, 32'h8000_0000, 8'h50);
    single("add carry",OP_ADD, 32'hFFFF_FFFF, 32'd1,  5'd0, 32'h0000_0000, 8'hA0);
    single("sub 3-5",  OP_SUB, 32'd3,         32'd5,  5'd0, 32'hFFFF_FFFE, 8'h30);
    single("slt -1,1", OP_SLT, 32'hFFFF_FFFF, 32'd1,  5'd0, 32'd1,         8'h08);
    single("xor",      OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 8'h00);
    single("nor",      OP_NOR, 32'd0,         32'd0,  5'd0, 32'hFFFF_FFFF, 8'h18);
    single("sll",      OP_SLL, 32'd1,         32'd0,  5'd31, 32'h8000_0000, 8'h10);
    single("srl",      OP_SRL, 32'h8000_0000, 32'd0,  5'd31, 32'd1,        8'h08);
    single("sra",      OP_SRA, 32'h8000_0000, 32'd0,  5'd4,  32'hF800_0000, 8'h10);
    single("unknown",  OP_UNK, 32'h1234_5678, 32'd9,  5'd3,  32'd0,        8'h80);
    single("div by 0", OP_DIV, 32'd5,         32'd0,  5'd0,  32'hFFFF_FFFF, 8'h1C);

    // Outputs hold on non-done cycles.
    @(posedge clk);
    #1;
    check("hold done",   {31'd0, done}, 32'd0);
    check("hold result", alu_result, 32'hFFFF_FFFF);
    check("hold status", {24'd0, alu_status}, 32'h1C);

    // MUL 0x10000*0x10000: 32 busy cycles, low word 0, ovf.
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0);
    check("mul busy", {31'd0, busy}, 32'd1);
    check("mul no early done", {31'd0, done}, 32'd0);
    wait_done(40, cycles);
    check("mul latency", cycles, 32'd32);
    check("mul busy at done", {31'd0, busy}, 32'd0);
    check("mul result", alu_result, 32'd0);
    check("mul status", {24'd0, alu_status}, 32'hC0);

    // MUL 3*5 with an ignored mid-op start and operand changes after acceptance.
    issue(OP_MUL, 32'd3, 32'd5, 5'd0);
    start = 1'b1; alu_ctrl = OP_ADD; operand_1 = 32'd100; operand_2 = 32'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mid-mul start busy", {31'd0, busy}, 32'd1);
    check("mid-mul start done", {31'd0, done}, 32'd0);
    wait_done(40, cycles);
    check("mul2 latency", cycles, 32'd31);
    check("mul2 result", alu_result, 32'd15);
    check("mul2 status", {24'd0, alu_status}, 32'h08);

    // DIV 100/7, then ADD in the done cycle: accepted with no bubble.
    issue(OP_DIV, 32'd100, 32'd7, 5'd0);
    wait_done(40, cycles);
    check("div latency", cycles, 32'd32);
    check("div result", alu_result, 32'd14);
    check("div status", {24'd0, alu_status}, 32'h00);
    start = 1'b1; alu_ctrl = OP_ADD; operand_1 = 32'd2; operand_2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b done",   {31'd0, done}, 32'd1);
    check("b2b busy",   {31'd0, busy}, 32'd0);
    check("b2b result", alu_result, 32'd5);
    check("b2b status", {24'd0, alu_status}, 32'h08);

    // Reset at MUL cycle 10 aborts the op.
    issue(OP_MUL, 32'd7, 32'd9, 5'd0);
    repeat (9) @(posedge clk);
    #2;
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst busy",   {31'd0, busy}, 32'd0);
    check("rst done",   {31'd0, done}, 32'd0);
    check("rst result", alu_result, 32'd0);
    check("rst status", {24'd0, alu_status}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("aborted op done pulses", pulses, 32'd0);
    single("and after rst", OP_AND, 32'hF0, 32'h3C, 5'd0, 32'h30, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
